hazard_bypass_ctrl: RTL and testbench
=====================================

Name: hazard_bypass_ctrl

Overview:
Forwarding and hazard controller that produces the bypass selects and stage write-enables consumed by the execute-stage ALU operand mux. It keeps shadow copies of the destination-register state for the X, M and W stages. From these it resolves RAW hazards for the instruction leaving decode, issuing MX or WX bypass selects and load-use stalls. It also applies branch flushes and memory-busy freezes to the same shadow pipeline.

Parameters:
REG_AW, 5, register-address width; x0 is address 0 and is never a hazard source.
SEL_NONE/SEL_MX/SEL_WX, 2'b00/2'b01/2'b10, bypass select encodings; 2'b11 is never driven.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
d_valid  in  1  decode stage holds a real instruction
d_rs1  in  REG_AW  decode source 1
d_rs2  in  REG_AW  decode source 2
d_uses_rs1  in  1  instruction reads rs1 (ASel = rs1)
d_uses_rs2  in  1  instruction reads rs2 (BSel = rs2, or store data)
d_rd  in  REG_AW  decode destination
d_reg_we  in  1  instruction writes rd
d_is_load  in  1  instruction is a load
x_branch_taken  in  1  branch/jump in X redirects fetch this cycle
mem_busy  in  1  data memory not ready; whole pipe freezes
bypass_sel_rs1  out  2  registered select for operand A of the instruction in X
bypass_sel_rs2  out  2  registered select for operand B of the instruction in X
m_write_enable  out  1  M-stage instruction is valid and writes rd
w_write_enable  out  1  W-stage instruction is valid and writes rd
stall_fd  out  1  hold the PC and the F/D register
bubble_x  out  1  load a NOP into the D/X register
flush_fd  out  1  discard the instructions in F and D

Behaviour:
- State: X/M/W shadow entries, each {valid, rd, we, is_load}; bypass_sel_rs1/rs2 registers.
- Reset (async, rst_n=0): all valid=0, rd=0, we=0, is_load=0, both selects SEL_NONE. m/w_write_enable, stall_fd, bubble_x and flush_fd are 0 because they are combinational from reset state and inputs.
- Hazard source predicate: match(S,r) = S.valid & S.we & (S.rd != 0) & (S.rd == r).
- Load-use hazard: lu = d_valid & X.is_load & ((d_uses_rs1 & match(X,d_rs1)) | (d_uses_rs2 & match(X,d_rs2))). This includes store-data use; the block is conservative and has no WM path.
- Next select per source r, computed only when d_uses_r is set: match(X,r) & !X.is_load -> SEL_MX; else match(M,r) -> SEL_WX; else SEL_NONE. The younger producer (X) has priority over M.
- W-stage producers are not forwarded. The register file is write-through, so a same-cycle W write is visible to decode.
- Combinational outputs:
  - m_write_enable = M.valid & M.we
  - w_write_enable = W.valid & W.we
  - stall_fd = mem_busy | (lu & !x_branch_taken)
  - flush_fd = x_branch_taken & !mem_busy
  - bubble_x = !mem_busy & (x_branch_taken | lu)
- Per-cycle update, in priority order:
  1. mem_busy=1: all shadow entries and selects hold. Branch and load-use effects are deferred until mem_busy drops, with x_branch_taken held by X.
  2. x_branch_taken=1: W<=M, M<=X, X<=invalid, selects<=SEL_NONE. This overrides a simultaneous lu.
  3. lu=1: W<=M, M<=X, X<=invalid (bubble), selects<=SEL_NONE. D holds and re-evaluates next cycle, when the load is in M and yields SEL_WX.
  4. Otherwise: W<=M, M<=X, X<={d_valid, d_rd, d_reg_we & d_valid, d_is_load & d_valid}, selects<=computed next values.
- d_valid=0 advances an invalid X entry and SEL_NONE selects.
- rd=x0 never matches, even when we=1.
- Back-to-back writers to the same rd: the youngest wins, per the MX-over-WX priority.
- Latency: selects are valid in the cycle the consumer occupies X (one register stage after decode). Load-use costs exactly one bubble.
- Reset mid-operation clears all shadow state immediately; the first post-reset decode sees no hazards.

Decomposition:
- Shared package hazard_pkg: SEL_NONE/SEL_MX/SEL_WX constants, REG_AW, and the stage_entry struct {valid, rd, we, is_load}.
- One sub-module, hazard_src_match: the combinational per-operand select/hazard resolver. It is instantiated twice (rs1, rs2) and takes the X/M entries plus r and uses_r.

Test Plan:
1. add x5 then add x6,x5,x1: second instr in X has bypass_sel_rs1=01, m_write_enable=1, no stall.
2. add x5; nop; sub x7,x2,x5: sub in X has bypass_sel_rs2=10, w_write_enable=1.
3. lw x5 then add x6,x5,x5: stall_fd=1 and bubble_x=1 for exactly one cycle; add enters X with both selects=10.
4. add x0,... then add x6,x0,x0: selects stay 00.
5. x_branch_taken=1 together with a load-use condition: flush_fd=1, bubble_x=1, stall_fd=0; next X entry invalid with selects 00.
6. mem_busy=1 for 3 cycles during scenario 1, then rst_n pulsed low mid-sequence: shadow state and selects hold during busy; all outputs return to 0/00 asynchronously on reset.

Source files
------------

// File: rtl/hazard_bypass_ctrl_pkg.sv
// Shared types for the hazard/bypass controller.
// Select encodings, register width and shadow stage entry.
package hazard_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_MX   = 2'b01;
    localparam logic [1:0] SEL_WX   = 2'b10;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      we;
        logic      is_load;
    } stage_entry_t;

    // x0 is hardwired, so it never produces a hazard
    function automatic logic src_match(
        input stage_entry_t s,
        input reg_addr_t    r
    );
        return s.valid && s.we && (s.rd != '0) && (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_bypass_ctrl_if.sv
// Decode/control bundle between the pipeline and the hazard controller.
// master drives decode and control inputs, slave returns selects and stalls.
interface hazard_bypass_ctrl_if;
    import hazard_pkg::*;

    logic       d_valid;
    reg_addr_t  d_rs1;
    reg_addr_t  d_rs2;
    logic       d_uses_rs1;
    logic       d_uses_rs2;
    reg_addr_t  d_rd;
    logic       d_reg_we;
    logic       d_is_load;
    logic       x_branch_taken;
    logic       mem_busy;
    logic [1:0] bypass_sel_rs1;
    logic [1:0] bypass_sel_rs2;
    logic       m_write_enable;
    logic       w_write_enable;
    logic       stall_fd;
    logic       bubble_x;
    logic       flush_fd;

    modport master (
        output d_valid, d_rs1, d_rs2, d_uses_rs1, d_uses_rs2,
        output d_rd, d_reg_we, d_is_load, x_branch_taken, mem_busy,
        input  bypass_sel_rs1, bypass_sel_rs2,
        input  m_write_enable, w_write_enable,
        input  stall_fd, bubble_x, flush_fd
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_uses_rs1, d_uses_rs2,
        input  d_rd, d_reg_we, d_is_load, x_branch_taken, mem_busy,
        output bypass_sel_rs1, bypass_sel_rs2,
        output m_write_enable, w_write_enable,
        output stall_fd, bubble_x, flush_fd
    );

endinterface

// File: rtl/hazard_src_match.sv
// Per-operand RAW resolver against the X and M shadow entries.
// Younger X producer beats M; a load in X flags load-use instead.
module hazard_src_match
    import hazard_pkg::*;
(
    input  stage_entry_t x_ent,
    input  stage_entry_t m_ent,
    input  reg_addr_t    r,
    input  logic         uses_r,
    output logic [1:0]   sel,
    output logic         lu_hit
);

    logic hit_x;
    logic hit_m;

    assign hit_x  = uses_r && src_match(x_ent, r);
    assign hit_m  = uses_r && src_match(m_ent, r);
    assign lu_hit = hit_x && x_ent.is_load;

    // priority select: MX from X, else WX from M
    always_comb begin
        sel = SEL_NONE;
        if (hit_x && !x_ent.is_load) begin
            sel = SEL_MX;
        end else if (hit_m) begin
            sel = SEL_WX;
        end
    end

endmodule

// File: rtl/hazard_bypass_ctrl.sv
// Forwarding and hazard controller with X/M/W destination shadows.
// Registers bypass selects for the instruction entering X.
module hazard_bypass_ctrl
    import hazard_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    hazard_bypass_ctrl_if.slave bus
);

    stage_entry_t x_q;
    stage_entry_t m_q;
    stage_entry_t w_q;
    logic [1:0]   sel1_q;
    logic [1:0]   sel2_q;

    logic [1:0]   sel1_nx;
    logic [1:0]   sel2_nx;
    logic         lu1;
    logic         lu2;
    logic         lu;
    stage_entry_t d_ent;

    hazard_src_match u_rs1 (
        .x_ent  (x_q),
        .m_ent  (m_q),
        .r      (bus.d_rs1),
        .uses_r (bus.d_uses_rs1),
        .sel    (sel1_nx),
        .lu_hit (lu1)
    );

    hazard_src_match u_rs2 (
        .x_ent  (x_q),
        .m_ent  (m_q),
        .r      (bus.d_rs2),
        .uses_r (bus.d_uses_rs2),
        .sel    (sel2_nx),
        .lu_hit (lu2)
    );

    assign lu = bus.d_valid && (lu1 || lu2);

    assign d_ent.valid   = bus.d_valid;
    assign d_ent.rd      = bus.d_rd;
    assign d_ent.we      = bus.d_reg_we && bus.d_valid;
    assign d_ent.is_load = bus.d_is_load && bus.d_valid;

    assign bus.bypass_sel_rs1 = sel1_q;
    assign bus.bypass_sel_rs2 = sel2_q;
    assign bus.m_write_enable = m_q.valid && m_q.we;
    assign bus.w_write_enable = w_q.valid && w_q.we;
    assign bus.stall_fd = bus.mem_busy || (lu && !bus.x_branch_taken);
    assign bus.flush_fd = bus.x_branch_taken && !bus.mem_busy;
    assign bus.bubble_x = !bus.mem_busy && (bus.x_branch_taken || lu);

    // shadow pipe advance; freeze on mem_busy, bubble on flush or load-use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            sel1_q <= SEL_NONE;
            sel2_q <= SEL_NONE;
        end else if (!bus.mem_busy) begin
            w_q <= m_q;
            m_q <= x_q;
            if (bus.x_branch_taken || lu) begin
                x_q    <= '0;
                sel1_q <= SEL_NONE;
                sel2_q <= SEL_NONE;
            end else begin
                x_q    <= d_ent;
                sel1_q <= bus.d_valid ? sel1_nx : SEL_NONE;
                sel2_q <= bus.d_valid ? sel2_nx : SEL_NONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
// Self-checking bench for hazard_bypass_ctrl.
// Directed pipeline scenarios plus random traffic against a stage model.
module tb_hazard_bypass_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_bypass_ctrl_if bus ();

    hazard_bypass_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // model: index 0 = X, 1 = M, 2 = W
    bit         mv  [3];
    int         mrd [3];
    bit         mwe [3];
    bit         mld [3];
    logic [1:0] es1;
    logic [1:0] es2;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 0; mrd[i] = 0; mwe[i] = 0; mld[i] = 0;
        end
        es1 = 2'b00;
        es2 = 2'b00;
    endtask

    // age of youngest forwardable writer of r: 0=X, 1=M, 3=none
    function automatic int nearest(int r);
        if (r == 0) return 3;
        for (int i = 0; i < 2; i++)
            if (mv[i] && mwe[i] && mrd[i] == r) return i;
        return 3;
    endfunction

    task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, int rs1, int rs2, bit u1, bit u2,
                         int rd, bit we, bit ld, bit br, bit busy);
        bus.d_valid        = v;
        bus.d_rs1          = reg_addr_t'(rs1);
        bus.d_rs2          = reg_addr_t'(rs2);
        bus.d_uses_rs1     = u1;
        bus.d_uses_rs2     = u2;
        bus.d_rd           = reg_addr_t'(rd);
        bus.d_reg_we       = we;
        bus.d_is_load      = ld;
        bus.x_branch_taken = br;
        bus.mem_busy       = busy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        int n1, n2;
        bit v, br, busy, lu;
        logic [1:0] s1, s2;
        #1;
        v    = bus.d_valid;
        br   = bus.x_branch_taken;
        busy = bus.mem_busy;
        n1 = bus.d_uses_rs1 ? nearest(int'(bus.d_rs1)) : 3;
        n2 = bus.d_uses_rs2 ? nearest(int'(bus.d_rs2)) : 3;
        lu = v && mld[0] && (n1 == 0 || n2 == 0);
        chk("sel_rs1", bus.bypass_sel_rs1, es1);
        chk("sel_rs2", bus.bypass_sel_rs2, es2);
        chk("m_we", {1'b0, bus.m_write_enable}, {1'b0, mv[1] & mwe[1]});
        chk("w_we", {1'b0, bus.w_write_enable}, {1'b0, mv[2] & mwe[2]});
        chk("stall", {1'b0, bus.stall_fd}, {1'b0, busy | (lu & ~br)});
        chk("flush", {1'b0, bus.flush_fd}, {1'b0, br & ~busy});
        chk("bubble", {1'b0, bus.bubble_x}, {1'b0, ~busy & (br | lu)});
        s1 = !v ? 2'b00 : (n1 == 0) ? 2'b01 : (n1 == 1) ? 2'b10 : 2'b00;
        s2 = !v ? 2'b00 : (n2 == 0) ? 2'b01 : (n2 == 1) ? 2'b10 : 2'b00;
        @(posedge clk);
        if (!busy) begin
            mv[2] = mv[1]; mrd[2] = mrd[1];
            mwe[2] = mwe[1]; mld[2] = mld[1];
            mv[1] = mv[0]; mrd[1] = mrd[0];
            mwe[1] = mwe[0]; mld[1] = mld[0];
            if (br || lu) begin
                mv[0] = 0; mrd[0] = 0; mwe[0] = 0; mld[0] = 0;
                es1 = 2'b00; es2 = 2'b00;
            end else begin
                mv[0]  = v;
                mrd[0] = int'(bus.d_rd);
                mwe[0] = v & bus.d_reg_we;
                mld[0] = v & bus.d_is_load;
                es1 = s1; es2 = s2;
            end
        end
        #1;
    endtask

    task automatic ins(int rd, int rs1, int rs2, bit u1, bit u2,
                       bit we, bit ld);
        drive(1, rs1, rs2, u1, u2, rd, we, ld, 0, 0);
        step();
    endtask

    task automatic nop();
        idle();
        step();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_sel1", bus.bypass_sel_rs1, 2'b00);
        chk("rst_sel2", bus.bypass_sel_rs2, 2'b00);
        chk("rst_mwe", {1'b0, bus.m_write_enable}, 2'b00);
        chk("rst_wwe", {1'b0, bus.w_write_enable}, 2'b00);
        chk("rst_stall", {1'b0, bus.stall_fd}, 2'b00);
        chk("rst_flush", {1'b0, bus.flush_fd}, 2'b00);
        chk("rst_bubble", {1'b0, bus.bubble_x}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #2;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: MX forward
        ins(5, 1, 2, 1, 1, 1, 0);
        ins(6, 5, 1, 1, 1, 1, 0);
        nop(); nop(); nop();

        // 2: WX forward on rs2
        ins(5, 1, 2, 1, 1, 1, 0);
        nop();
        ins(7, 2, 5, 1, 1, 1, 0);
        nop(); nop(); nop();

        // 3: load-use, one bubble then WX on both
        ins(5, 1, 0, 1, 0, 1, 1);
        ins(6, 5, 5, 1, 1, 1, 0);
        ins(6, 5, 5, 1, 1, 1, 0);
        nop(); nop(); nop();

        // 4: x0 never forwards
        ins(0, 1, 2, 1, 1, 1, 0);
        ins(6, 0, 0, 1, 1, 1, 0);
        nop(); nop(); nop();

        // 5: branch overrides load-use
        ins(5, 1, 0, 1, 0, 1, 1);
        drive(1, 5, 2, 1, 1, 6, 1, 0, 1, 0);
        step();
        nop(); nop(); nop();

        // 6: busy freeze, then async reset mid-sequence
        ins(5, 1, 2, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
            step();
        end
        ins(6, 5, 1, 1, 1, 1, 0);
        ins(7, 6, 5, 1, 1, 1, 0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ins(6, 5, 7, 1, 1, 1, 0);
        nop(); nop();

        // random traffic over a small register set
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
